// File: rtl/aclk_key_entry.sv
// Keypad entry for the alarm clock: ASCII keys to a 4-digit BCD key buffer.
// Optional hh:mm range check on completion: define ACLK_KEY_RANGE_CHECK_EN.
module aclk_key_entry #(
   parameter int TIMEOUT_CYCLES = 10
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       key_valid,
   input  logic [7:0] key_ascii,
   output logic       key_ready,
   output logic [3:0] key_ms_hr,
   output logic [3:0] key_ls_hr,
   output logic [3:0] key_ms_min,
   output logic [3:0] key_ls_min,
   output logic [2:0] digit_count,
   output logic       entry_done,
   output logic       entry_error,
   output logic       entry_timeout
);

   localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ENTRY = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t        state;
   logic [TW-1:0] tmo_cnt;
   logic          accept;
   logic          is_digit;
   logic          is_star;
   logic [3:0]    d;
   logic          range_ok;

   assign accept   = key_valid & key_ready;
   assign is_digit = (key_ascii >= 8'h30) && (key_ascii <= 8'h39);
   assign is_star  = (key_ascii == 8'h2A);
   assign d        = key_ascii[3:0];

`ifdef ACLK_KEY_RANGE_CHECK_EN
   // Candidate after the 4th shift: hours = ls_hr:ms_min, min tens = ls_min
   logic [6:0] cand_hrs;
   assign cand_hrs = {3'b000, key_ls_hr} * 7'd10 + {3'b000, key_ms_min};
   assign range_ok = (cand_hrs <= 7'd23) && (key_ls_min <= 4'd5);
`else
   assign range_ok = 1'b1;
`endif

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state         <= IDLE;
         tmo_cnt       <= '0;
         key_ready     <= 1'b1;
         key_ms_hr     <= 4'd0;
         key_ls_hr     <= 4'd0;
         key_ms_min    <= 4'd0;
         key_ls_min    <= 4'd0;
         digit_count   <= 3'd0;
         entry_done    <= 1'b0;
         entry_error   <= 1'b0;
         entry_timeout <= 1'b0;
      end else begin
         entry_done    <= 1'b0;
         entry_error   <= 1'b0;
         entry_timeout <= 1'b0;
         case (state)
            DONE: begin
               state     <= IDLE;
               key_ready <= 1'b1;
               tmo_cnt   <= '0;
            end
            IDLE, ENTRY: begin
               if (accept) begin
                  tmo_cnt <= '0;
                  unique case (1'b1)
                     is_star: begin
                        state       <= IDLE;
                        key_ms_hr   <= 4'd0;
                        key_ls_hr   <= 4'd0;
                        key_ms_min  <= 4'd0;
                        key_ls_min  <= 4'd0;
                        digit_count <= 3'd0;
                     end
                     is_digit: begin
                        if (state == IDLE) begin
                           state       <= ENTRY;
                           key_ms_hr   <= 4'd0;
                           key_ls_hr   <= 4'd0;
                           key_ms_min  <= 4'd0;
                           key_ls_min  <= d;
                           digit_count <= 3'd1;
                        end else if (digit_count == 3'd3 && !range_ok) begin
                           state       <= IDLE;
                           key_ms_hr   <= 4'd0;
                           key_ls_hr   <= 4'd0;
                           key_ms_min  <= 4'd0;
                           key_ls_min  <= 4'd0;
                           digit_count <= 3'd0;
                           entry_error <= 1'b1;
                        end else begin
                           key_ms_hr   <= key_ls_hr;
                           key_ls_hr   <= key_ms_min;
                           key_ms_min  <= key_ls_min;
                           key_ls_min  <= d;
                           digit_count <= digit_count + 3'd1;
                           if (digit_count == 3'd3) begin
                              state      <= DONE;
                              key_ready  <= 1'b0;
                              entry_done <= 1'b1;
                           end
                        end
                     end
                     default: entry_error <= 1'b1;
                  endcase
               end else if (state == ENTRY) begin
                  if (tmo_cnt == TMO_LAST) begin
                     state         <= IDLE;
                     tmo_cnt       <= '0;
                     key_ms_hr     <= 4'd0;
                     key_ls_hr     <= 4'd0;
                     key_ms_min    <= 4'd0;
                     key_ls_min    <= 4'd0;
                     digit_count   <= 3'd0;
                     entry_timeout <= 1'b1;
                  end else begin
                     tmo_cnt <= tmo_cnt + TW'(1);
                  end
               end else begin
                  tmo_cnt <= '0;
               end
            end
            default: begin
               state     <= IDLE;
               key_ready <= 1'b1;
               tmo_cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_aclk_key_entry.sv
// Bench for aclk_key_entry: directed cases plus random keys
// against a behavioural model of the key buffer.
module tb_aclk_key_entry;

   localparam int TMO = 10;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       key_valid = 1'b0;
   logic [7:0] key_ascii = 8'h00;
   logic       key_ready;
   logic [3:0] key_ms_hr, key_ls_hr, key_ms_min, key_ls_min;
   logic [2:0] digit_count;
   logic       entry_done, entry_error, entry_timeout;

   aclk_key_entry #(.TIMEOUT_CYCLES(TMO)) dut (
      .clock(clock),
      .reset_n(reset_n),
      .key_valid(key_valid),
      .key_ascii(key_ascii),
      .key_ready(key_ready),
      .key_ms_hr(key_ms_hr),
      .key_ls_hr(key_ls_hr),
      .key_ms_min(key_ms_min),
      .key_ls_min(key_ls_min),
      .digit_count(digit_count),
      .entry_done(entry_done),
      .entry_error(entry_error),
      .entry_timeout(entry_timeout)
   );

   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_on = 1'b0;

   // model: digit buffer as an array, left = hours tens
   int  m_dig[4];
   int  m_cnt;
   bit  m_active;
   bit  m_done;
   int  m_idle;
   int  e_done, e_err, e_tmo;

   task automatic cmp(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic clear_buf();
      for (int i = 0; i < 4; i++) m_dig[i] = 0;
      m_cnt = 0;
   endtask

   function automatic bit time_ok(input int h1, input int h0, input int m1);
`ifdef ACLK_KEY_RANGE_CHECK_EN
      return (h1 * 10 + h0 <= 23) && (m1 <= 5);
`else
      return 1'b1;
`endif
   endfunction

   task automatic model_step(input bit v, input int a, input bit r);
      e_done = 0;
      e_err  = 0;
      e_tmo  = 0;
      if (!r) begin
         clear_buf();
         m_active = 0;
         m_done   = 0;
         m_idle   = 0;
      end else if (m_done) begin
         m_done = 0;
         m_idle = 0;
      end else if (v) begin
         m_idle = 0;
         if (a == 'h2A) begin
            clear_buf();
            m_active = 0;
         end else if (a >= 'h30 && a <= 'h39) begin
            if (!m_active) begin
               clear_buf();
               m_dig[3] = a - 'h30;
               m_cnt    = 1;
               m_active = 1;
            end else if (m_cnt == 3
                         && !time_ok(m_dig[1], m_dig[2], m_dig[3])) begin
               clear_buf();
               m_active = 0;
               e_err    = 1;
            end else begin
               m_dig[0] = m_dig[1];
               m_dig[1] = m_dig[2];
               m_dig[2] = m_dig[3];
               m_dig[3] = a - 'h30;
               m_cnt++;
               if (m_cnt == 4) begin
                  m_done   = 1;
                  m_active = 0;
                  e_done   = 1;
               end
            end
         end else begin
            e_err = 1;
         end
      end else if (m_active) begin
         m_idle++;
         if (m_idle == TMO) begin
            clear_buf();
            m_active = 0;
            m_idle   = 0;
            e_tmo    = 1;
         end
      end
   endtask

   always @(negedge clock) begin
      if (chk_on) begin
         cmp("key_ready", int'(key_ready), int'(!m_done));
         cmp("key_ms_hr", int'(key_ms_hr), m_dig[0]);
         cmp("key_ls_hr", int'(key_ls_hr), m_dig[1]);
         cmp("key_ms_min", int'(key_ms_min), m_dig[2]);
         cmp("key_ls_min", int'(key_ls_min), m_dig[3]);
         cmp("digit_count", int'(digit_count), m_cnt);
         cmp("entry_done", int'(entry_done), e_done);
         cmp("entry_error", int'(entry_error), e_err);
         cmp("entry_timeout", int'(entry_timeout), e_tmo);
      end
   end

   task automatic step(input bit v, input logic [7:0] a, input bit r);
      key_valid = v;
      key_ascii = a;
      reset_n   = r;
      @(posedge clock);
      model_step(v, int'(a), r);
      #1;
   endtask

   task automatic key(input logic [7:0] a);
      step(1'b1, a, 1'b1);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b1);
   endtask

   function automatic int digits();
      return {16'd0, key_ms_hr, key_ls_hr, key_ms_min, key_ls_min};
   endfunction

   initial begin
      clear_buf();
      m_active = 0;
      m_done   = 0;
      m_idle   = 0;
      e_done   = 0;
      e_err    = 0;
      e_tmo    = 0;
      step(1'b0, 8'h00, 1'b0);
      chk_on = 1'b1;
      cmp("rst_digits", digits(), 'h0000);
      cmp("rst_count", int'(digit_count), 0);
      cmp("rst_ready", int'(key_ready), 1);

      key("1"); key("2"); key("3"); key("4");
      cmp("seq1234_digits", digits(), 'h1234);
      cmp("seq1234_done", int'(entry_done), 1);
      cmp("done_ready", int'(key_ready), 0);
      key("9");
      cmp("drop_in_done", digits(), 'h1234);
      cmp("done_one_cycle", int'(entry_done), 0);
      cmp("ready_back", int'(key_ready), 1);
      idle(1);

      key("0"); key("7");
      idle(TMO - 1);
      cmp("no_tmo_early", int'(entry_timeout), 0);
      idle(1);
      cmp("tmo_pulse", int'(entry_timeout), 1);
      cmp("tmo_digits", digits(), 'h0000);
      cmp("tmo_count", int'(digit_count), 0);
      idle(1);

      key("1"); key("2"); key(8'h41);
      cmp("bad_key_err", int'(entry_error), 1);
      cmp("bad_key_digits", digits(), 'h0012);
      cmp("bad_key_count", int'(digit_count), 2);

      key("*");
      cmp("star_digits", digits(), 'h0000);
      cmp("star_count", int'(digit_count), 0);
      key("5");
      cmp("fresh_digits", digits(), 'h0005);

      key("*");
      key("2"); key("5"); key("0"); key("0");
`ifdef ACLK_KEY_RANGE_CHECK_EN
      cmp("range_err", int'(entry_error), 1);
      cmp("range_no_done", int'(entry_done), 0);
      cmp("range_cleared", digits(), 'h0000);
`else
      cmp("norange_done", int'(entry_done), 1);
      cmp("norange_digits", digits(), 'h2500);
`endif
      idle(1);

      key("3"); key("1");
      step(1'b1, "4", 1'b0);
      cmp("mid_rst_digits", digits(), 'h0000);
      cmp("mid_rst_count", int'(digit_count), 0);
      cmp("mid_rst_ready", int'(key_ready), 1);

      for (int i = 0; i < 4000; i++) begin
         int pv;
         int sel;
         logic [7:0] a;
         pv  = ((i / 200) % 2 == 0) ? 75 : 15;
         sel = $urandom_range(99);
         if (sel < 70)      a = 8'h30 + 8'($urandom_range(9));
         else if (sel < 78) a = 8'h2A;
         else               a = 8'($urandom_range(255));
         step($urandom_range(99) < pv, a, $urandom_range(199) != 0);
      end

      idle(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
